// File: rtl/handshake_pkg.sv
// Shared constants, state encoding and pointer helper for the handshake layer arbiters.
package handshake_pkg;

  localparam int unsigned HS_N_REQ  = 4;
  localparam int unsigned HS_DATA_W = 8;
  localparam int unsigned HS_ID_W   = 2;

  // The output slot either holds nothing or holds one buffered transfer.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } hs_state_e;

  // Advance a round-robin pointer by one, wrapping at n back to 0.
  function automatic int unsigned hs_ptr_inc(input int unsigned ptr, input int unsigned n);
    int unsigned nxt;
    if (ptr + 32'd1 >= n) begin
      nxt = 32'd0;
    end else begin
      nxt = ptr + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/handshake_rr_arbiter_chk.sv
// Protocol checker for the arbiter's downstream channel and upstream readies.
module handshake_rr_arbiter_chk #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ID_W   = 2
) (
  input logic              clk,
  input logic              rst,
  input logic [N_REQ-1:0]  req_ready,
  input logic              m_valid,
  input logic [DATA_W-1:0] m_data,
  input logic [ID_W-1:0]   m_id,
  input logic              m_ready
);

  // At most one requester is ever offered ready.
  a_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready));

  // A stalled output holds its contents and offers no upstream ready.
  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_id)));

  a_stall_no_ready: assert property (@(posedge clk)
    (m_valid && !m_ready) |-> (req_ready == '0));

  // Reset always forces readies low.
  a_rst_no_ready: assert property (@(posedge clk) rst |-> (req_ready == '0));

endmodule

// File: rtl/handshake_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: the first asserted request strictly after
// last_grant, found by priority-encoding a doubled request vector with the
// positions before the start point masked off.
module rr_pick
  import handshake_pkg::*;
#(
  parameter int unsigned N_REQ = HS_N_REQ,
  parameter int unsigned ID_W  = HS_ID_W
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  output logic [N_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any
);

  localparam int unsigned W2 = 2 * N_REQ;

  logic [ID_W-1:0] start_s;
  logic [W2-1:0]   dbl_s;
  logic [W2-1:0]   masked_s;
  int unsigned     pos_s;
  logic            found_s;

  // Start of the scan and the doubled request vector with bits below the start cleared.
  always_comb begin
    start_s  = ID_W'(hs_ptr_inc(32'(last_grant), N_REQ));
    dbl_s    = {req, req};
    masked_s = '0;
    for (int j = 0; j < int'(W2); j++) begin
      if (j >= int'(start_s)) begin
        masked_s[j] = dbl_s[j];
      end else begin
        masked_s[j] = 1'b0;
      end
    end
  end

  // Lowest set position of the masked vector; the upper copy guarantees a hit whenever any req is set.
  always_comb begin
    pos_s   = 32'd0;
    found_s = 1'b0;
    for (int j = 0; j < int'(W2); j++) begin
      if (masked_s[j] && !found_s) begin
        pos_s   = 32'(j);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Fold the doubled position back to a requester index and form the outputs.
  always_comb begin
    any       = |req;
    grant_idx = ID_W'(pos_s % N_REQ);
    if (any) begin
      grant_onehot = N_REQ'(1'b1) << grant_idx;
    end else begin
      grant_onehot = '0;
    end
  end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output slot between
// N_REQ upstream requesters; tags each buffered payload with its source index.
module handshake_rr_arbiter
  import handshake_pkg::*;
#(
  parameter int unsigned N_REQ  = HS_N_REQ,
  parameter int unsigned DATA_W = HS_DATA_W,
  parameter int unsigned ID_W   = HS_ID_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    m_valid,
  output logic [DATA_W-1:0]       m_data,
  output logic [ID_W-1:0]         m_id,
  input  logic                    m_ready,
  output logic                    busy
);

  hs_state_e         state_r;
  hs_state_e         state_nxt_s;
  logic [DATA_W-1:0] data_r;
  logic [DATA_W-1:0] data_nxt_s;
  logic [ID_W-1:0]   id_r;
  logic [ID_W-1:0]   id_nxt_s;
  logic [ID_W-1:0]   last_grant_r;
  logic [ID_W-1:0]   last_grant_nxt_s;

  logic [N_REQ-1:0]  pick_onehot_s;
  logic [ID_W-1:0]   pick_idx_s;
  logic              pick_any_s;
  logic              can_accept_s;
  logic              up_xfer_s;
  logic [DATA_W-1:0] sel_data_s;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req          (req_valid),
    .last_grant   (last_grant_r),
    .grant_onehot (pick_onehot_s),
    .grant_idx    (pick_idx_s),
    .any          (pick_any_s)
  );

  // Payload of the current winner.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (pick_onehot_s[i]) begin
        sel_data_s = req_data[i*DATA_W +: DATA_W];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Ready to the winner whenever the slot is empty or drains this cycle; never during reset.
  always_comb begin
    can_accept_s = (state_r == ST_EMPTY) || m_ready;
    if (can_accept_s && !rst) begin
      req_ready = pick_onehot_s;
    end else begin
      req_ready = '0;
    end
    up_xfer_s = pick_any_s && can_accept_s && !rst;
  end

  // Next state of the output slot and the priority pointer.
  always_comb begin
    state_nxt_s      = state_r;
    data_nxt_s       = data_r;
    id_nxt_s         = id_r;
    last_grant_nxt_s = last_grant_r;
    case (state_r)
      ST_EMPTY: begin
        if (up_xfer_s) begin
          state_nxt_s      = ST_FULL;
          data_nxt_s       = sel_data_s;
          id_nxt_s         = pick_idx_s;
          last_grant_nxt_s = pick_idx_s;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (up_xfer_s) begin
          // Drain and reload on the same edge keeps one transfer per cycle.
          state_nxt_s      = ST_FULL;
          data_nxt_s       = sel_data_s;
          id_nxt_s         = pick_idx_s;
          last_grant_nxt_s = pick_idx_s;
        end else if (m_ready) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
      end
    endcase
  end

  // Output slot and pointer registers; reset points last_grant at the top so requester 0 leads.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_EMPTY;
      data_r       <= '0;
      id_r         <= '0;
      last_grant_r <= ID_W'(N_REQ - 32'd1);
    end else begin
      state_r      <= state_nxt_s;
      data_r       <= data_nxt_s;
      id_r         <= id_nxt_s;
      last_grant_r <= last_grant_nxt_s;
    end
  end

  assign m_valid = (state_r == ST_FULL);
  assign m_data  = data_r;
  assign m_id    = id_r;
  assign busy    = (state_r == ST_FULL);

  handshake_rr_arbiter_chk #(
    .N_REQ  (N_REQ),
    .DATA_W (DATA_W),
    .ID_W   (ID_W)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .req_ready (req_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_id      (m_id),
    .m_ready   (m_ready)
  );

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a behavioural model.
module tb_handshake_rr_arbiter;

  localparam int N = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          m_valid;
  logic [7:0]    m_data;
  logic [1:0]    m_id;
  logic          m_ready;
  logic          busy;

  int n_checks;
  int n_fail;

  // Behavioural model: slot contents and who was served last.
  int         mfull;
  logic [7:0] mdata;
  int         mid;
  int         mlg;

  handshake_rr_arbiter #(.N_REQ(4), .DATA_W(8), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_id      (m_id),
    .m_ready   (m_ready),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First valid requester after the last one served, wrapping; -1 if none.
  function automatic int model_winner();
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (mlg + k) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    int w;
    w = model_winner();
    if (w >= 0 && (mfull == 0 || m_ready) && !rst) return 4'(1 << w);
    return 4'b0000;
  endfunction

  // One clock: compare everything against the model, advance the model, move to next negedge.
  task automatic cycle();
    int w;
    #1;
    chk("m_valid", 32'(m_valid), 32'(mfull));
    chk("busy", 32'(busy), 32'(mfull));
    chk("m_data", 32'(m_data), 32'(mdata));
    chk("m_id", 32'(m_id), 32'(mid));
    chk("req_ready", 32'(req_ready), 32'(model_ready()));
    w = model_winner();
    if (rst) begin
      mfull = 0; mdata = 8'h00; mid = 0; mlg = N - 1;
    end else if (w >= 0 && (mfull == 0 || m_ready)) begin
      mfull = 1; mdata = req_data[w*8 +: 8]; mid = w; mlg = w;
    end else if (mfull != 0 && m_ready) begin
      mfull = 0;
    end
    @(negedge clk);
  endtask

  task automatic set_data(input int i, input logic [7:0] v);
    req_data[i*8 +: 8] = v;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    mfull = 0; mdata = 8'h00; mid = 0; mlg = N - 1;
    rst = 1'b1; req_valid = 4'b1111; m_ready = 1'b0; req_data = '0;
    for (int i = 0; i < N; i++) set_data(i, 8'hA0 + 8'(i));
    @(negedge clk);

    // Reset held two cycles with every requester valid.
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_valid", 32'(m_valid), 32'h0);
      cycle();
    end

    // Round-robin under full load with no backpressure.
    rst = 1'b0; m_ready = 1'b1;
    #1 chk("rr_first_ready", 32'(req_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("rr_id", 32'(m_id), 32'(k % 4));
      chk("rr_data", 32'(m_data), 32'(8'hA0 + 8'(k % 4)));
    end

    // Backpressure: load 5C from requester 2 then stall.
    req_valid = 4'b0100; set_data(2, 8'h5C);
    cycle();
    chk("bp_load_id", 32'(m_id), 32'd2);
    req_valid = 4'b1111; m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_ready", 32'(req_ready), 32'h0);
      chk("bp_data", 32'(m_data), 32'h5C);
      chk("bp_id", 32'(m_id), 32'd2);
      chk("bp_valid", 32'(m_valid), 32'd1);
      cycle();
    end
    m_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(req_ready), 32'h8);
    cycle();
    chk("bp_next_id", 32'(m_id), 32'd3);
    chk("bp_next_valid", 32'(m_valid), 32'd1);

    // Sparse: requesters 1 and 3, starting from last_grant = 1.
    req_valid = 4'b0010;
    cycle();
    req_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      #1 chk("sp_ready", 32'(req_ready), (k % 2 == 0) ? 32'h8 : 32'h2);
      cycle();
      chk("sp_id", 32'(m_id), (k % 2 == 0) ? 32'd3 : 32'd1);
    end

    // Single requester streaming 11, 22, 33.
    req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      set_data(2, 8'h11 * 8'(k + 1));
      cycle();
      chk("single_id", 32'(m_id), 32'd2);
      chk("single_data", 32'(m_data), 32'(8'h11 * 8'(k + 1)));
    end

    // Reset while 77 sits stalled in the slot.
    set_data(2, 8'h77);
    cycle();
    req_valid = 4'b0000; m_ready = 1'b0;
    cycle();
    chk("mid_hold", 32'(m_data), 32'h77);
    rst = 1'b1;
    cycle();
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    rst = 1'b0; req_valid = 4'b1111; m_ready = 1'b1;
    #1 chk("mid_rst_prio", 32'(req_ready), 32'h1);
    cycle();

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_data  = 32'($urandom);
      m_ready   = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 59) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
